// File: rtl/loopmac_swap_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : loopmac_swap_fifo
// Brief    : Store-and-forward MAC RX->TX loopback buffer; drops bad/runt/
//            overflowed frames and swaps DA<->SA on replay.
// Revision : 1.0 - initial release
// ============================================================================
module loopmac_swap_fifo #(
    parameter int ADDR_W  = 12,
    parameter int DESC_W  = 4,
    parameter int MIN_LEN = 14,
    parameter bit SWAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    output logic        tx_tuser,
    input  logic        tx_tready,
    output logic [31:0] cnt_fwd,
    output logic [31:0] cnt_drop
);
    localparam int                c_DEPTH      = 1 << ADDR_W;
    localparam int                c_DESC_DEPTH = 1 << DESC_W;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [15:0]       c_MIN_LEN    = 16'(MIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    logic [7:0]        r_mem        [c_DEPTH];
    logic [ADDR_W-1:0] r_desc_start [c_DESC_DEPTH];
    logic [15:0]       r_desc_len   [c_DESC_DEPTH];

    logic              r_armed;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_frame_start;
    logic [ADDR_W-1:0] r_rel_ptr;
    logic [ADDR_W-1:0] r_cur_start;
    logic [15:0]       r_len;
    logic [15:0]       r_cur_len;
    logic [15:0]       r_idx;
    logic [DESC_W:0]   r_dwr;
    logic [DESC_W:0]   r_drd;
    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_rd_data;
    logic              r_tx_last;
    logic [31:0]       r_cnt_fwd;
    logic [31:0]       r_cnt_drop;

    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [15:0]       w_len_next;
    logic [15:0]       w_rd_idx;
    logic              w_writable;
    logic              w_wr_en;
    logic              w_commit;
    logic              w_drop;
    logic              w_desc_empty;
    logic              w_desc_full;
    logic              w_pop;
    logic              w_rd_en;
    logic              w_done;

    // Output byte i is fetched from frame offset f_map(i): SA first, then DA.
    function automatic logic [15:0] f_map(input logic [15:0] idx);
        if (!SWAP_EN || idx >= 16'd12) return idx;
        else if (idx < 16'd6)          return idx + 16'd6;
        else                           return idx - 16'd6;
    endfunction

    assign w_wr_next    = r_wr_ptr + c_ADDR_ONE;
    assign w_writable   = (w_wr_next != r_rel_ptr);
    assign w_len_next   = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
    assign w_wr_en      = r_armed && rx_tvalid && !r_ovf && w_writable;
    assign w_desc_empty = (r_dwr == r_drd);
    assign w_desc_full  = (r_dwr[DESC_W] != r_drd[DESC_W]) &&
                          (r_dwr[DESC_W-1:0] == r_drd[DESC_W-1:0]);
    assign w_commit     = r_armed && rx_tvalid && rx_tlast && !rx_tuser && w_wr_en &&
                          (w_len_next >= c_MIN_LEN) && !w_desc_full;
    assign w_drop       = r_armed && rx_tvalid && rx_tlast && !w_commit;

    // Write side: the unarmed state swallows a frame already in progress at reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed       <= 1'b0;
            r_ovf         <= 1'b0;
            r_wr_ptr      <= '0;
            r_frame_start <= '0;
            r_len         <= '0;
        end else if (!r_armed) begin
            if (!rx_tvalid) r_armed <= 1'b1;
        end else if (rx_tvalid) begin
            if (w_wr_en)     r_wr_ptr <= w_wr_next;
            if (!w_writable) r_ovf    <= 1'b1;
            r_len <= w_len_next;
            if (rx_tlast) begin
                r_len <= '0;
                r_ovf <= 1'b0;
                if (w_commit) r_frame_start <= w_wr_next;
                else          r_wr_ptr      <= r_frame_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= rx_tdata;
        if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_desc_start[r_dwr[DESC_W-1:0]] <= r_frame_start;
            r_desc_len[r_dwr[DESC_W-1:0]]   <= w_len_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwr <= '0;
            r_drd <= '0;
        end else begin
            if (w_commit) r_dwr <= r_dwr + 1'b1;
            if (w_pop)    r_drd <= r_drd + 1'b1;
        end
    end

    // Read FSM next-state and read-port control.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_idx     = r_idx;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_desc_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rd_en      = 1'b1;
                w_rd_idx     = 16'd0;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                if (tx_tready) begin
                    if (r_tx_last) begin
                        w_done = 1'b1;
                        if (!w_desc_empty) begin
                            w_pop        = 1'b1;
                            w_state_next = S_LOAD;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_rd_en  = 1'b1;
                        w_rd_idx = r_idx + 16'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_rd_addr = r_cur_start + ADDR_W'(f_map(w_rd_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_start <= '0;
            r_cur_len   <= '0;
            r_idx       <= '0;
            r_tx_last   <= 1'b0;
            r_rel_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_cur_start <= r_desc_start[r_drd[DESC_W-1:0]];
                r_cur_len   <= r_desc_len[r_drd[DESC_W-1:0]];
            end
            if (w_rd_en) begin
                r_idx     <= w_rd_idx;
                r_tx_last <= (w_rd_idx == r_cur_len - 16'd1);
            end
            // Buffer space is returned only once the whole frame has left.
            if (w_done) begin
                r_tx_last <= 1'b0;
                r_rel_ptr <= r_cur_start + ADDR_W'(r_cur_len);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_fwd  <= '0;
            r_cnt_drop <= '0;
        end else begin
            if (w_done) r_cnt_fwd  <= r_cnt_fwd + 32'd1;
            if (w_drop) r_cnt_drop <= r_cnt_drop + 32'd1;
        end
    end

    assign tx_tvalid = (r_state == S_SEND);
    assign tx_tlast  = tx_tvalid && r_tx_last;
    assign tx_tdata  = tx_tvalid ? r_rd_data : 8'd0;
    assign tx_tuser  = 1'b0;
    assign cnt_fwd   = r_cnt_fwd;
    assign cnt_drop  = r_cnt_drop;

endmodule
`default_nettype wire
